// File: rtl/exc_pkg.sv
// exc_ctrl shared definitions: exception codes,
// controller FSM states and TCFG field positions.
package exc_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_FLUSH  = 2'd2,
    S_REDIR  = 2'd3
  } exc_state_t;

  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int TCFG_INIT_LSB = 2;

endpackage

// File: rtl/exc_timer.sv
// Constant timer: TCFG load, TVAL countdown, TICLR.
// Drives the timer interrupt status bit ESTAT.IS[11].
module exc_timer
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  input  logic        ticlr_clr,
  output logic [31:0] tval,
  output logic        timer_int
);

  logic        en;
  logic        periodic;
  logic [31:0] reload;
  logic [31:0] load_val;
  logic        hit;

  assign load_val = {tcfg_wdata[31:TCFG_INIT_LSB], 2'b00};
  assign hit      = en & ~tcfg_we & (tval == 32'd0);

  // Configuration load and countdown; a write beats the count step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      reload   <= '0;
      tval     <= '0;
    end else if (tcfg_we) begin
      en       <= tcfg_wdata[TCFG_EN];
      periodic <= tcfg_wdata[TCFG_PERIODIC];
      reload   <= load_val;
      tval     <= load_val;
    end else if (en) begin
      if (tval == 32'd0) begin
        if (periodic) tval <= reload;
        else          en   <= 1'b0;
      end else begin
        tval <= tval - 32'd1;
      end
    end
  end

  // Interrupt status; expiry in the same cycle beats a clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        timer_int <= 1'b0;
    else if (hit)       timer_int <= 1'b1;
    else if (ticlr_clr) timer_int <= 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between WB and the CSR file.
// Optional constant timer enabled by EXC_CTRL_TIMER_EN.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        wb_exc_ine,
  input  logic        wb_exc_sys,
  input  logic        wb_exc_brk,
  input  logic        wb_exc_ale,
  input  logic        wb_ertn,
  input  logic [7:0]  hw_int,
  input  logic        csr_crmd_ie,
  input  logic [12:0] csr_ecfg_lie,
  input  logic [12:0] csr_estat_is,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wdata,
  input  logic        ticlr_clr,
  output logic        ex_commit,
  output logic [5:0]  ex_ecode,
  output logic [8:0]  ex_esubcode,
  output logic [31:0] ex_pc,
  output logic        ex_badv_we,
  output logic [31:0] ex_badv,
  output logic        ertn_commit,
  output logic        flush,
  output logic        redirect,
  output logic        redirect_sel,
  output logic [31:0] tval,
  output logic        timer_int,
  output logic        int_pending,
  output logic        busy
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  exc_state_t  state_q, state_d;
  logic [CW-1:0] cnt;
  logic [12:0] is_eff;
  logic        any_exc;
  logic        event_go;
  logic        take;
  logic [5:0]  ecode_n;
  logic        sel_ertn;
  logic        sel_ale;
  logic        unused_bits;

`ifdef EXC_CTRL_TIMER_EN
  exc_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .tcfg_we    (tcfg_we),
    .tcfg_wdata (tcfg_wdata),
    .ticlr_clr  (ticlr_clr),
    .tval       (tval),
    .timer_int  (timer_int)
  );
  assign unused_bits = csr_estat_is[11];
`else
  assign tval        = '0;
  assign timer_int   = 1'b0;
  assign unused_bits = ^{csr_estat_is[11], tcfg_we,
                         tcfg_wdata, ticlr_clr};
`endif

  assign is_eff = {csr_estat_is[12], timer_int, csr_estat_is[10],
                   hw_int, csr_estat_is[1:0]};
  assign int_pending = csr_crmd_ie & (|(csr_ecfg_lie & is_eff));
  assign any_exc  = wb_exc_ine | wb_exc_sys | wb_exc_brk | wb_exc_ale;
  assign event_go = wb_valid & (int_pending | any_exc | wb_ertn);
  assign take     = (state_q == S_IDLE) & event_go;

  // Cause selection in fixed priority order
  always_comb begin
    ecode_n  = ECODE_INT;
    sel_ertn = 1'b0;
    sel_ale  = 1'b0;
    if (int_pending)     ecode_n = ECODE_INT;
    else if (wb_exc_ine) ecode_n = ECODE_INE;
    else if (wb_exc_sys) ecode_n = ECODE_SYS;
    else if (wb_exc_brk) ecode_n = ECODE_BRK;
    else if (wb_exc_ale) begin
      ecode_n = ECODE_ALE;
      sel_ale = 1'b1;
    end else begin
      sel_ertn = 1'b1;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (event_go) state_d = S_COMMIT;
      S_COMMIT: state_d = S_FLUSH;
      S_FLUSH:  if (cnt == '0) state_d = S_REDIR;
      S_REDIR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counts the cycles spent in FLUSH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt <= '0;
    else if (state_q == S_COMMIT)
      cnt <= CW'(FLUSH_CYCLES - 1);
    else if (state_q == S_FLUSH && cnt != '0)
      cnt <= cnt - CW'(1);
  end

  // Registered commit strobes and payload
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_commit    <= 1'b0;
      ertn_commit  <= 1'b0;
      ex_badv_we   <= 1'b0;
      ex_ecode     <= '0;
      ex_pc        <= '0;
      ex_badv      <= '0;
      redirect_sel <= 1'b0;
    end else begin
      ex_commit   <= 1'b0;
      ertn_commit <= 1'b0;
      ex_badv_we  <= 1'b0;
      if (take) begin
        if (sel_ertn) begin
          ertn_commit  <= 1'b1;
          redirect_sel <= 1'b1;
        end else begin
          ex_commit    <= 1'b1;
          ex_ecode     <= ecode_n;
          ex_pc        <= wb_pc;
          redirect_sel <= 1'b0;
          if (sel_ale) begin
            ex_badv_we <= 1'b1;
            ex_badv    <= wb_vaddr;
          end
        end
      end
    end
  end

  assign ex_esubcode = '0;
  assign flush    = (state_q == S_COMMIT) | (state_q == S_FLUSH);
  assign redirect = (state_q == S_REDIR);
  assign busy     = (state_q != S_IDLE);

endmodule
